// File: rtl/data_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// data_bus_arbiter_if
//   Bundle of every handshake/bus signal around data_bus_arbiter: two
//   requesting masters on one side, a single data-bus target on the other,
//   plus the grant/busy status outputs.
//
//   Access-type encoding (`MEM_ACCESS is the field width):
//     `MEM_ACCESS_R  read      `MEM_ACCESS_W  write      `MEM_ACCESS_X  fetch
//
//   Modports
//     slave  : the arbiter's view (it serves both masters and drives db_*)
//     master : the surroundings' view (masters + bus target + status monitor)
//
//   Signals (per master i in {0,1})
//     mi_req, mi_addr[31:0], mi_dataOut[31:0], mi_accessType, mi_io  -> arbiter
//     mi_ready, mi_err, mi_dataIn[31:0]                              <- arbiter
//     db_addr[31:0], db_dataOut[31:0], db_accessType, db_io          <- arbiter
//     db_ready, db_dataIn[31:0]                                      -> arbiter
//     grant[1:0], busy                                               <- arbiter
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_BUS_ARBITER_DEFS
`define DATA_BUS_ARBITER_DEFS
`define MEM_ACCESS   [1:0]
`define MEM_ACCESS_R 2'b00
`define MEM_ACCESS_W 2'b01
`define MEM_ACCESS_X 2'b10
`endif

interface data_bus_arbiter_if;
  // master 0
  logic                m0_req;
  logic [31:0]         m0_addr;
  logic [31:0]         m0_dataOut;
  logic `MEM_ACCESS    m0_accessType;
  logic                m0_io;
  logic                m0_ready;
  logic                m0_err;
  logic [31:0]         m0_dataIn;
  // master 1
  logic                m1_req;
  logic [31:0]         m1_addr;
  logic [31:0]         m1_dataOut;
  logic `MEM_ACCESS    m1_accessType;
  logic                m1_io;
  logic                m1_ready;
  logic                m1_err;
  logic [31:0]         m1_dataIn;
  // data-bus target
  logic [31:0]         db_addr;
  logic [31:0]         db_dataOut;
  logic `MEM_ACCESS    db_accessType;
  logic                db_io;
  logic                db_ready;
  logic [31:0]         db_dataIn;
  // status
  logic [1:0]          grant;
  logic                busy;

  modport slave (
    input  m0_req, m0_addr, m0_dataOut, m0_accessType, m0_io,
    input  m1_req, m1_addr, m1_dataOut, m1_accessType, m1_io,
    input  db_ready, db_dataIn,
    output m0_ready, m0_err, m0_dataIn,
    output m1_ready, m1_err, m1_dataIn,
    output db_addr, db_dataOut, db_accessType, db_io,
    output grant, busy
  );

  modport master (
    output m0_req, m0_addr, m0_dataOut, m0_accessType, m0_io,
    output m1_req, m1_addr, m1_dataOut, m1_accessType, m1_io,
    output db_ready, db_dataIn,
    input  m0_ready, m0_err, m0_dataIn,
    input  m1_ready, m1_err, m1_dataIn,
    input  db_addr, db_dataOut, db_accessType, db_io,
    input  grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/data_bus_arbiter.sv
//------------------------------------------------------------------------------
// data_bus_arbiter
//   Two-master round-robin arbiter for a single data bus. A granted request is
//   latched onto db_*, held in ADDR until the target answers with db_ready
//   (or the wait counter times out), then one DATA cycle returns db_dataIn to
//   the owner together with a one-cycle m<i>_ready pulse.
//
//   Parameters
//     PRIO_RESET : master that wins the first contended arbitration after reset
//     TIMEOUT    : db_ready-low cycles tolerated in ADDR before abort (0 = off)
//
//   Ports
//     clk : clock, rising edge
//     res : asynchronous active-low reset
//     bus : data_bus_arbiter_if.slave (master requests, bus target, status)
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_bus_arbiter #(
  parameter bit         PRIO_RESET = 1'b0,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic               clk,
  input  logic               res,
  data_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Abort fires on the edge where the counter already holds TIMEOUT-1, so the
  // owner sees exactly TIMEOUT db_ready-low ADDR cycles before its err pulse.
  localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

  state_t            state_q, state_d;
  logic              last_q,  last_d;    // master granted most recently
  logic              owner_q, owner_d;   // master owning the current transfer
  logic [7:0]        wait_q,  wait_d;
  logic [31:0]       addr_q,  addr_d;
  logic [31:0]       dout_q,  dout_d;
  logic `MEM_ACCESS  type_q,  type_d;
  logic              io_q,    io_d;
  logic [1:0]        rdy_q,   rdy_d;
  logic [1:0]        err_q,   err_d;
  logic [31:0]       din0_q,  din0_d;
  logic [31:0]       din1_q,  din1_d;

  logic [1:0]        req_vec;
  logic              winner;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      // Tracking "last granted" means the other master is favoured next, so
      // starting from ~PRIO_RESET hands the first tie to PRIO_RESET.
      last_q  <= ~PRIO_RESET;
      owner_q <= 1'b0;
      wait_q  <= 8'd0;
      addr_q  <= 32'd0;
      dout_q  <= 32'd0;
      type_q  <= `MEM_ACCESS_R;
      io_q    <= 1'b0;
      rdy_q   <= 2'b00;
      err_q   <= 2'b00;
      din0_q  <= 32'd0;
      din1_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      type_q  <= type_d;
      io_q    <= io_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    type_d  = type_q;
    io_d    = io_q;
    rdy_d   = 2'b00;
    err_d   = 2'b00;
    din0_d  = din0_q;
    din1_d  = din1_q;

    // A master still seeing its ready pulse is not re-arbitrated this cycle,
    // which is what keeps one master from being served twice back-to-back.
    req_vec = {bus.m1_req & ~rdy_q[1], bus.m0_req & ~rdy_q[0]};
    winner  = (&req_vec) ? ~last_q : req_vec[1];

    case (state_q)
      S_IDLE: begin
        if (|req_vec) begin
          state_d = S_ADDR;
          owner_d = winner;
          last_d  = winner;
          wait_d  = 8'd0;
          if (winner) begin
            addr_d = bus.m1_addr;
            dout_d = bus.m1_dataOut;
            type_d = bus.m1_accessType;
            io_d   = bus.m1_io;
          end else begin
            addr_d = bus.m0_addr;
            dout_d = bus.m0_dataOut;
            type_d = bus.m0_accessType;
            io_d   = bus.m0_io;
          end
        end
      end

      S_ADDR: begin
        // A target answering on the very last allowed cycle still wins.
        if (bus.db_ready) begin
          state_d = S_DATA;
        end else if ((TIMEOUT != 8'd0) && (wait_q == TO_LAST)) begin
          state_d = S_IDLE;
          err_d   = owner_q ? 2'b10 : 2'b01;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end

      S_DATA: begin
        state_d = S_IDLE;
        rdy_d   = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          din1_d = bus.db_dataIn;
        end else begin
          din0_d = bus.db_dataIn;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.m0_ready      = rdy_q[0];
  assign bus.m1_ready      = rdy_q[1];
  assign bus.m0_err        = err_q[0];
  assign bus.m1_err        = err_q[1];
  assign bus.m0_dataIn     = din0_q;
  assign bus.m1_dataIn     = din1_q;

  // Address/data keep their last value; type and io are only presented in ADDR.
  assign bus.db_addr       = addr_q;
  assign bus.db_dataOut    = dout_q;
  assign bus.db_accessType = (state_q == S_ADDR) ? type_q : `MEM_ACCESS_R;
  assign bus.db_io         = (state_q == S_ADDR) & io_q;

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.grant         = (state_q == S_IDLE) ? 2'b00 :
                             (owner_q ? 2'b10 : 2'b01);

endmodule

`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_data_bus_arbiter
//   Self-checking bench for data_bus_arbiter (TIMEOUT = 4, PRIO_RESET = 0).
//   A small memory plays the bus target; a vector table drives single
//   transactions and hand sequences cover reset and contention.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_bus_arbiter;

  localparam logic [1:0] AT_R = 2'b00;
  localparam logic [1:0] AT_W = 2'b01;
  localparam logic [1:0] AT_X = 2'b10;

  logic clk;
  logic res;
  int   n_tests;
  int   n_fail;

  data_bus_arbiter_if bus_if ();

  data_bus_arbiter #(
    .PRIO_RESET (1'b0),
    .TIMEOUT    (8'd4)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // ---------------- bus target model ----------------
  logic [31:0] mem [0:1023];
  logic        ph_w;
  logic [9:0]  ph_a;
  logic [31:0] ph_d;

  always @(negedge clk) begin
    ph_w             <= (bus_if.db_accessType == AT_W);
    ph_a             <= bus_if.db_addr[9:0];
    ph_d             <= bus_if.db_dataOut;
    bus_if.db_dataIn <= mem[bus_if.db_addr[9:0]];
  end

  always @(posedge clk) begin
    if (!res) begin
      mem[10'h100] <= 32'hDEADBEEF;
    end else if (ph_w && bus_if.db_ready) begin
      mem[ph_a] <= ph_d;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_m(input bit m, input bit req, input logic [1:0] at,
                         input logic [31:0] a, input logic [31:0] d, input bit io);
    if (m) begin
      bus_if.m1_req = req; bus_if.m1_accessType = at; bus_if.m1_addr = a;
      bus_if.m1_dataOut = d; bus_if.m1_io = io;
    end else begin
      bus_if.m0_req = req; bus_if.m0_accessType = at; bus_if.m0_addr = a;
      bus_if.m0_dataOut = d; bus_if.m0_io = io;
    end
  endtask

  function automatic logic get_rdy(input bit m);
    return m ? bus_if.m1_ready : bus_if.m0_ready;
  endfunction
  function automatic logic get_err(input bit m);
    return m ? bus_if.m1_err : bus_if.m0_err;
  endfunction
  function automatic logic [31:0] get_din(input bit m);
    return m ? bus_if.m1_dataIn : bus_if.m0_dataIn;
  endfunction
  function automatic logic any_pulse();
    return bus_if.m0_ready | bus_if.m1_ready | bus_if.m0_err | bus_if.m1_err;
  endfunction

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((bus_if.busy || any_pulse()) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'd0, bus_if.busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " grant"},   {30'd0, bus_if.grant}, 32'd0);
    chk({tag, " busy"},    {31'd0, bus_if.busy}, 32'd0);
    chk({tag, " pulses"},  {28'd0, bus_if.m1_err, bus_if.m0_err, bus_if.m1_ready, bus_if.m0_ready}, 32'd0);
    chk({tag, " m0_din"},  bus_if.m0_dataIn, 32'd0);
    chk({tag, " m1_din"},  bus_if.m1_dataIn, 32'd0);
    chk({tag, " db_addr"}, bus_if.db_addr, 32'd0);
    chk({tag, " db_dout"}, bus_if.db_dataOut, 32'd0);
    chk({tag, " db_type"}, {30'd0, bus_if.db_accessType}, {30'd0, AT_R});
    chk({tag, " db_io"},   {31'd0, bus_if.db_io}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          mst;
    bit          io;
    logic [1:0]  atype;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;   // db_ready-low ADDR cycles offered by the target
    bit          exp_err;
    int          exp_lat;  // negedges after the grant negedge until the pulse
    logic [31:0] exp_din;
    int          exp_io;   // cycles db_io is seen high
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] other_before;
    int          got;
    int          io_cnt;
    bit          saw_rdy, saw_err, saw_other;
    @(negedge clk);
    bus_if.db_ready = 1'b0;
    drive_m(v.mst, 1'b1, v.atype, v.addr, v.wdata, v.io);
    other_before = get_din(!v.mst);
    @(negedge clk);
    chk($sformatf("v%0d grant", idx), {30'd0, bus_if.grant}, v.mst ? 32'd2 : 32'd1);
    chk($sformatf("v%0d db_type", idx), {30'd0, bus_if.db_accessType}, {30'd0, v.atype});
    // Scramble the master's fields: the latched request must not move.
    drive_m(v.mst, 1'b0, ~v.atype, ~v.addr, ~v.wdata, !v.io);
    got = -1; io_cnt = 0; saw_rdy = 0; saw_err = 0; saw_other = 0;
    for (int k = 0; k < 12; k++) begin
      if (any_pulse()) begin
        got       = k;
        saw_rdy   = get_rdy(v.mst);
        saw_err   = get_err(v.mst);
        saw_other = get_rdy(!v.mst) | get_err(!v.mst);
        break;
      end
      if (bus_if.db_io) begin
        io_cnt++;
        chk($sformatf("v%0d io addr", idx), bus_if.db_addr, v.addr);
        chk($sformatf("v%0d io data", idx), bus_if.db_dataOut, v.wdata);
      end
      bus_if.db_ready = (k >= v.wait_n);
      @(negedge clk);
    end
    chk($sformatf("v%0d latency", idx), got, v.exp_lat);
    chk($sformatf("v%0d ready", idx), {31'd0, saw_rdy}, {31'd0, !v.exp_err});
    chk($sformatf("v%0d err", idx), {31'd0, saw_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d other pulse", idx), {31'd0, saw_other}, 32'd0);
    chk($sformatf("v%0d dataIn", idx), get_din(v.mst), v.exp_din);
    chk($sformatf("v%0d other dataIn", idx), get_din(!v.mst), other_before);
    chk($sformatf("v%0d io cycles", idx), io_cnt, v.exp_io);
    @(negedge clk);
    bus_if.db_ready = 1'b0;
    chk($sformatf("v%0d pulse width", idx), {31'd0, any_pulse()}, 32'd0);
    chk($sformatf("v%0d idle", idx), {31'd0, bus_if.busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] seq [4];
    logic [1:0] prev;
    int         n;

    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    res = 1'b1;
    bus_if.db_ready = 1'b0;
    drive_m(1'b0, 1'b0, AT_R, 32'd0, 32'd0, 1'b0);
    drive_m(1'b1, 1'b0, AT_R, 32'd0, 32'd0, 1'b0);

    //                 mst  io   type  addr          wdata         wait err lat din           io
    vecs[0] = '{1'b1, 1'b0, AT_W, 32'h0000_0200, 32'h1234_5678, 0, 1'b0, 2, 32'h1234_5678, 0};
    vecs[1] = '{1'b0, 1'b0, AT_R, 32'h0000_0200, 32'h0000_0000, 0, 1'b0, 2, 32'h1234_5678, 0};
    vecs[2] = '{1'b0, 1'b1, AT_W, 32'h0000_0001, 32'h0000_0041, 0, 1'b0, 2, 32'h0000_0041, 1};
    vecs[3] = '{1'b1, 1'b0, AT_R, 32'h0000_0100, 32'h0000_0000, 3, 1'b0, 5, 32'hDEAD_BEEF, 0};
    vecs[4] = '{1'b0, 1'b0, AT_R, 32'h0000_0100, 32'h0000_0000, 4, 1'b1, 4, 32'h0000_0041, 0};
    vecs[5] = '{1'b1, 1'b0, AT_X, 32'h0000_0001, 32'h0000_0000, 1, 1'b0, 3, 32'h0000_0041, 0};
    vecs[6] = '{1'b1, 1'b0, AT_R, 32'h0000_0200, 32'h0000_0000, 7, 1'b1, 4, 32'h0000_0041, 0};
    vecs[7] = '{1'b0, 1'b0, AT_R, 32'h0000_0200, 32'h0000_0000, 2, 1'b0, 4, 32'h1234_5678, 0};

    // Power-on reset.
    #2 res = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    res = 1'b1;

    // Contention: both masters request continuously.
    @(negedge clk);
    bus_if.db_ready = 1'b1;
    drive_m(1'b0, 1'b1, AT_R, 32'h100, 32'd0, 1'b0);
    drive_m(1'b1, 1'b1, AT_R, 32'h100, 32'd0, 1'b0);
    prev = 2'b00;
    n    = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus_if.grant != 2'b00 && prev == 2'b00) begin
        seq[n] = bus_if.grant;
        n++;
      end
      prev = bus_if.grant;
    end
    bus_if.m0_req = 1'b0;
    bus_if.m1_req = 1'b0;
    chk("rr grant count", n, 4);
    chk("rr grant 0", {30'd0, seq[0]}, 32'd1);
    chk("rr grant 1", {30'd0, seq[1]}, 32'd2);
    chk("rr grant 2", {30'd0, seq[2]}, 32'd1);
    chk("rr grant 3", {30'd0, seq[3]}, 32'd2);
    wait_idle("rr idle");
    chk("rr m0 din", bus_if.m0_dataIn, 32'hDEADBEEF);
    @(negedge clk);

    // Reset while m0 sits in ADDR with an io write.
    bus_if.db_ready = 1'b0;
    drive_m(1'b0, 1'b1, AT_W, 32'h55, 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    chk("mid busy", {31'd0, bus_if.busy}, 32'd1);
    chk("mid db_io", {31'd0, bus_if.db_io}, 32'd1);
    chk("mid db_addr", bus_if.db_addr, 32'h55);
    bus_if.m0_req = 1'b0;
    #2 res = 1'b0;
    #1 chk_reset_outputs("mid");
    @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-rst quiet", {29'd0, any_pulse(), bus_if.grant}, 32'd0);
    end

    // m0 was granted last before reset; the pointer must be back at m0 anyway.
    bus_if.db_ready = 1'b1;
    drive_m(1'b0, 1'b1, AT_R, 32'h100, 32'd0, 1'b0);
    drive_m(1'b1, 1'b1, AT_R, 32'h100, 32'd0, 1'b0);
    @(negedge clk);
    chk("post-rst first grant", {30'd0, bus_if.grant}, 32'd1);
    bus_if.m0_req = 1'b0;
    bus_if.m1_req = 1'b0;
    wait_idle("post-rst idle");
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
